mp_arbiter: RTL and testbench
=============================

# mp_arbiter

Time-shares one pipelined signed 24×24 fractional multiplier among `NUM_CH` requesters, such as mixer channels and volume stages.
- Grants at most one request per cycle, round-robin.
- Carries the channel tag alongside the multiplier pipeline.
- Returns each product to its originating channel with a one-cycle valid pulse.

It sits between the per-channel DSP blocks and the single `mpemu` instance, which it owns.

## Interface
- `NUM_CH`, default 4: number of requesters, 2..8.
- `MP_LATENCY`, default 5: pipeline depth of the multiplier core; must equal the `mpemu` stage count.
- `clk  in  1`: the only clock.
- `rst  in  1`: synchronous, active-high reset.
- `req_i  in  NUM_CH`: per-channel request, held until acked.
- `a_i  in  NUM_CH*24`: channel n multiplicand at `[24n+23:24n]`, signed Q1.23.
- `b_i  in  NUM_CH*24`: channel n multiplier, same packing.
- `ack_o  out  NUM_CH`: one-hot grant, combinational from `req_i` and the pointer.
- `prod_o  out  24`: product, shared by all channels.
- `prod_valid_o  out  NUM_CH`: one-hot, marks which channel `prod_o` belongs to this cycle.
- `busy_o  out  1`: high while any issued product has not yet been returned.

## Operation
- **Arbitration:** `rr_ptr` is the highest-priority channel this cycle.
  - Grant the first asserted `req_i` bit found scanning from `rr_ptr` upward, wrapping modulo `NUM_CH`.
  - After a grant to channel g, `rr_ptr` becomes (g+1) mod `NUM_CH`.
  - With no request, `rr_ptr` holds.
- **Handshake:** a transfer occurs in a cycle where `req_i[n]` and `ack_o[n]` are both high.
  - Operands are captured at that edge.
  - The requester deasserts `req_i`, or presents the next operand pair, on the following cycle.
  - A requester may keep `req_i` high to issue back-to-back. It is granted again only when its round-robin turn comes, or when it is the sole requester.
- **Issue stage:**
  - On a transfer, the granted operands are registered into the multiplier inputs, and `{1, g}` enters the tag delay line.
  - With no transfer, the multiplier inputs hold and `{0, x}` enters the tag line.
- **Tag delay line:** `MP_LATENCY`+1 entries of {valid, channel index}, aligned so the tag exits with the corresponding multiplier output.
- **Output register:**
  - `prod_o` is the registered multiplier output.
  - `prod_valid_o` is the one-hot decode of the exiting tag, or 0 when the tag is invalid.
- **Arithmetic:** prod = bits [46:23] of signed(a)×signed(b).
  - This is an arithmetic shift right by 23, truncated toward −∞, with no saturation.
  - −1.0×−1.0 wraps to 0x800000.
- **`busy_o`:** OR of all valid bits in the tag line plus the output stage.

## Timing
- Transfer in cycle t gives `prod_valid_o[g]` = 1 in cycle t+`MP_LATENCY`+2, i.e. t+7 by default.
- `prod_o` is valid in that same cycle only.
- Throughput: one product per cycle, aggregate across all channels.
- Results return in issue order, with no reordering.
- Reset values, in the cycle after `rst` is high:
  - `rr_ptr` = 0.
  - All tag valid bits = 0.
  - `prod_valid_o` = 0, `prod_o` = 0, `busy_o` = 0.
  - `ack_o` = 0 while `rst` is high.
- Reset mid-operation: in-flight products are discarded, and no `prod_valid_o` pulse appears for any transfer made before reset.
- Simultaneous requests from all channels: grants rotate 0,1,2,3,0,… starting at `rr_ptr`.
- A single requester holding `req_i` is acked every cycle.
- Garbage still draining through the multiplier datapath is harmless, because only tags qualify output.

## Structure
- A shared package `mp_pkg` holds:
  - `MP_W` = 24.
  - `MP_FRAC` = 23.
  - `MP_LATENCY` = 5.
  - The channel-index type, sized $clog2(8).
- Sub-module: one `mpemu` instance. The arbiter, issue registers, tag line and output register are local logic.
- A separate `rr_arbiter` is not warranted; the round-robin scan stays inline.

## Test plan
- **Single request:** ch1 issues a=0x400000, b=0x400000 at cycle 10.
  - Expect `prod_valid_o` = 0b0010 and `prod_o` = 0x200000 at cycle 17.
  - `busy_o` is high for cycles 11..17.
- **All four channels requesting continuously from reset:**
  - `ack_o` sequence is 0001, 0010, 0100, 1000, 0001.
  - Valid pulses follow the same one-hot order, 7 cycles later.
- **Extremes:**
  - 0x7FFFFF×0x7FFFFF gives 0x7FFFFE.
  - 0x800000×0x800000 gives 0x800000.
  - 0xFFFFFF×0x000001 gives 0xFFFFFF.
  - 0x800000×0x400000 gives 0xC00000.
- **Sole requester:** ch2 holds `req_i` for 20 cycles with incrementing a and b=0x7FFFFF.
  - Expect 20 consecutive acks and 20 consecutive valid pulses with matching products.
- **Reset mid-flight:** issue on ch0 and ch3, then assert `rst` 3 cycles later for 1 cycle.
  - Expect no `prod_valid_o` pulses afterwards.
  - `busy_o` = 0 and `rr_ptr` = 0, so the next simultaneous 0/3 request grants ch0 first.
- **Gapped requests:** random request patterns, checked against a reference model for order, latency and value. No dropped or duplicated results.

Source files
------------

// File: rtl/mp_pkg.sv
// mp_pkg: shared constants and types for the multiplier arbiter slice.
//   MP_W        sample width (signed Q1.23)
//   MP_FRAC     fractional bits; the product is renormalised by this shift
//   MP_LATENCY  pipeline depth of the mpemu multiplier core
//   ch_idx_t    channel index, wide enough for the maximum of 8 requesters
//   sample_t    signed Q1.23 sample
//   mul_req_t   operand pair presented to the multiplier
//   frac_mul()  Q1.23 x Q1.23 -> Q1.23, floor rounding, wraps instead of saturating
package mp_pkg;

    localparam int MP_W       = 24;
    localparam int MP_FRAC    = 23;
    localparam int MP_LATENCY = 5;
    localparam int MAX_CH     = 8;
    localparam int CH_W       = $clog2(MAX_CH);

    typedef logic [CH_W-1:0]        ch_idx_t;
    typedef logic signed [MP_W-1:0] sample_t;

    typedef struct packed {
        sample_t a;
        sample_t b;
    } mul_req_t;

    // Full 48-bit product, arithmetic shift down by the fraction width, keep the
    // low 24 bits. -1.0 * -1.0 = +1.0 is not representable and wraps to 0x800000.
    function automatic sample_t frac_mul(input sample_t a, input sample_t b);
        logic signed [2*MP_W-1:0] full;
        full = a * b;
        return sample_t'(full >>> MP_FRAC);
    endfunction

endpackage

// File: rtl/mpemu.sv
// mpemu: pipelined signed Q1.23 fractional multiplier core.
//   clk    clock
//   a, b   operands, sampled every cycle
//   p      frac_mul(a, b), STAGES cycles after the operands were sampled
// The pipeline runs freely with no reset and no enable; whoever owns it must
// qualify the output with its own valid tracking.
module mpemu
    import mp_pkg::*;
#(
    parameter int STAGES = mp_pkg::MP_LATENCY
) (
    input  logic            clk,
    input  logic [MP_W-1:0] a,
    input  logic [MP_W-1:0] b,
    output logic [MP_W-1:0] p
);

    sample_t stage [STAGES];

    always_ff @(posedge clk) begin
        stage[0] <= frac_mul(sample_t'(a), sample_t'(b));
        for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign p = stage[STAGES-1];

endmodule

// File: rtl/mp_arbiter.sv
// mp_arbiter: time-shares one mpemu multiplier among NUM_CH requesters.
//   clk           clock
//   rst           synchronous active-high reset
//   req_i         per-channel request, held until acked
//   a_i, b_i      per-channel operands, channel n at [24n+23:24n]
//   ack_o         one-hot grant, combinational from req_i and the rr pointer
//   prod_o        shared product output
//   prod_valid_o  one-hot owner of prod_o this cycle
//   busy_o        some issued product has not yet been returned
// A transfer in cycle t returns in cycle t+MP_LATENCY+2: one cycle in the issue
// register, MP_LATENCY in mpemu, one in the output register. A tag line of
// MP_LATENCY+1 entries follows the operands so the channel index exits together
// with its product. NUM_CH must be in 2..8.
module mp_arbiter
    import mp_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int MP_LATENCY = mp_pkg::MP_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      req_i,
    input  logic [NUM_CH*MP_W-1:0] a_i,
    input  logic [NUM_CH*MP_W-1:0] b_i,
    output logic [NUM_CH-1:0]      ack_o,
    output logic [MP_W-1:0]        prod_o,
    output logic [NUM_CH-1:0]      prod_valid_o,
    output logic                   busy_o
);

    ch_idx_t  rr_ptr;
    ch_idx_t  ptr_next;
    logic     grant_vld;
    ch_idx_t  grant_ch;
    mul_req_t grant_ops;
    mul_req_t issue_ops;

    // Tag line: entry 0 is aligned with the issue register, entry MP_LATENCY
    // with the mpemu output.
    logic    [MP_LATENCY:0] vld_pipe;
    ch_idx_t                ch_pipe [MP_LATENCY+1];

    logic [MP_W-1:0]   mul_p;
    logic [NUM_CH-1:0] pv_next;

    // Round-robin scan split into two passes over fixed channel indices: the
    // lowest requester at or above rr_ptr wins; otherwise the lowest one below
    // it, which is the wrapped part of the scan.
    always_comb begin
        logic    found_hi;
        logic    found_lo;
        ch_idx_t g_hi;
        ch_idx_t g_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        g_hi     = '0;
        g_lo     = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (req_i[j] && !rst) begin
                if (j >= int'(rr_ptr)) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        g_hi     = ch_idx_t'(j);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    g_lo     = ch_idx_t'(j);
                end
            end
        end
        grant_vld = found_hi | found_lo;
        grant_ch  = found_hi ? g_hi : g_lo;
    end

    always_comb begin
        ack_o     = '0;
        grant_ops = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (grant_vld && grant_ch == ch_idx_t'(j)) begin
                ack_o[j]    = 1'b1;
                grant_ops.a = sample_t'(a_i[j*MP_W +: MP_W]);
                grant_ops.b = sample_t'(b_i[j*MP_W +: MP_W]);
            end
        end
    end

    assign ptr_next = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + ch_idx_t'(1);

    always_comb begin
        pv_next = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            pv_next[j] = vld_pipe[MP_LATENCY] && (ch_pipe[MP_LATENCY] == ch_idx_t'(j));
        end
    end

    // Control state: pointer, tag valids and output stage are reset so no
    // pulse can escape for a transfer made before reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            vld_pipe     <= '0;
            prod_valid_o <= '0;
            prod_o       <= '0;
        end else begin
            if (grant_vld) begin
                rr_ptr <= ptr_next;
            end
            vld_pipe     <= {vld_pipe[MP_LATENCY-1:0], grant_vld};
            prod_valid_o <= pv_next;
            prod_o       <= mul_p;
        end
    end

    // Datapath without reset: stale operands and indices are masked by the
    // valid bits. Issue registers hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            issue_ops <= grant_ops;
        end
        ch_pipe[0] <= grant_ch;
        for (int i = 1; i <= MP_LATENCY; i++) begin
            ch_pipe[i] <= ch_pipe[i-1];
        end
    end

    mpemu #(
        .STAGES (MP_LATENCY)
    ) u_mpemu (
        .clk (clk),
        .a   (issue_ops.a),
        .b   (issue_ops.b),
        .p   (mul_p)
    );

    assign busy_o = (|vld_pipe) | (|prod_valid_o);

endmodule

// File: tb/tb_mp_arbiter.sv
module tb_mp_arbiter;

    localparam int N = 4;
    localparam int L = 5;
    localparam int W = 24;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_bus, b_bus;
    logic [N-1:0]   ack, pv;
    logic [W-1:0]   prod;
    logic           busy;

    always #5 clk = ~clk;

    mp_arbiter #(.NUM_CH(N), .MP_LATENCY(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .a_i          (a_bus),
        .b_i          (b_bus),
        .ack_o        (ack),
        .prod_o       (prod),
        .prod_valid_o (pv),
        .busy_o       (busy)
    );

    typedef struct {
        int          ch;
        logic [23:0] p;
        int          due;
    } exp_t;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] p;
    } vec_t;

    exp_t        q[$];
    int          ptr, cyc, vectors, miscompares, issued, recv;
    logic [23:0] opa [N];
    logic [23:0] opb [N];
    logic [N-1:0] last_ack, last_pv;
    logic [23:0]  last_prod;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference product from plain integer arithmetic: floor((a*b)/2^23), low 24 bits.
    function automatic logic [23:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
        longint pa, pb, r;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        r  = (pa * pb) >>> 23;
        return r[23:0];
    endfunction

    task automatic drive();
        for (int n = 0; n < N; n++) begin
            a_bus[n*W +: W] = opa[n];
            b_bus[n*W +: W] = opb[n];
        end
    endtask

    // One clock cycle: compare outputs at the falling edge against the model,
    // then advance the model across the rising edge.
    task automatic step();
        logic [N-1:0] eack, epv;
        logic [23:0]  eprod;
        int           g;
        exp_t         e;
        drive();
        @(negedge clk);
        eack = '0;
        g    = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr + k) % N;
                if (g < 0 && req[c]) g = c;
            end
        end
        if (g >= 0) eack[g] = 1'b1;
        chk("ack", 32'(ack), 32'(eack));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        epv   = '0;
        eprod = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            epv[e.ch] = 1'b1;
            eprod = e.p;
        end
        chk("valid", 32'(pv), 32'(epv));
        if (epv != 0) chk("prod", 32'(prod), 32'(eprod));
        if (pv != 0) recv++;
        last_ack  = ack;
        last_pv   = pv;
        last_prod = prod;
        if (g >= 0) begin
            q.push_back('{g, ref_mul(opa[g], opb[g]), cyc + L + 2});
            ptr = (g + 1) % N;
            issued++;
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            issued -= q.size();
            q.delete();
            ptr = 0;
        end
        #1;
    endtask

    task automatic refresh_acked();
        for (int n = 0; n < N; n++) begin
            if (last_ack[n]) begin
                opa[n] = 24'($urandom);
                opb[n] = 24'($urandom);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t         tbl [5];
        logic [N-1:0] seq_exp [5];
        logic [N-1:0] seq [8];
        logic [N-1:0] pending;
        int           nack, npv, nrst;

        tbl[0] = '{24'h400000, 24'h400000, 24'h200000};
        tbl[1] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFE};
        tbl[2] = '{24'h800000, 24'h800000, 24'h800000};
        tbl[3] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF};
        tbl[4] = '{24'h800000, 24'h400000, 24'hC00000};
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;

        vectors = 0; miscompares = 0; issued = 0; recv = 0; ptr = 0; cyc = 0;
        for (int n = 0; n < N; n++) begin
            opa[n] = '0;
            opb[n] = '0;
        end
        rst = 1'b1;
        req = '1;
        drive();
        repeat (2) @(posedge clk);
        #1;

        // Reset state; requests present while rst is high must not be acked.
        step();
        chk("reset_prod", 32'(last_prod), 32'h0);
        rst = 1'b0;
        req = '0;
        repeat (3) step();

        // Single-channel vectors on ch1, result checked 7 cycles after issue.
        for (int i = 0; i < 5; i++) begin
            opa[1] = tbl[i].a;
            opb[1] = tbl[i].b;
            req    = 4'b0010;
            step();
            req = '0;
            repeat (7) step();
            chk("tbl_prod", 32'(last_prod), 32'(tbl[i].p));
            chk("tbl_valid", 32'(last_pv), 32'h2);
        end

        // All channels requesting from reset: grants rotate from channel 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = '1;
        for (int i = 0; i < 8; i++) begin
            step();
            seq[i] = last_ack;
            refresh_acked();
        end
        for (int i = 0; i < 5; i++) chk("rr_seq", 32'(seq[i]), 32'(seq_exp[i]));
        req = '0;
        repeat (9) step();

        // Sole requester holding req: acked every cycle.
        nack = 0;
        npv  = 0;
        req  = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            opa[2] = 24'h000100 + 24'(i * 4097);
            opb[2] = 24'h7FFFFF;
            step();
            if (last_ack == 4'b0100) nack++;
            if (last_pv == 4'b0100) npv++;
        end
        req = '0;
        repeat (9) begin
            step();
            if (last_pv == 4'b0100) npv++;
        end
        chk("sole_acks", 32'(nack), 32'd20);
        chk("sole_valids", 32'(npv), 32'd20);

        // Reset with two products in flight: neither may come out.
        opa[0] = 24'h123456; opb[0] = 24'h654321;
        opa[3] = 24'h7ABCDE; opb[3] = 24'h811111;
        req = 4'b1001;
        step();
        step();
        req = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nrst = 0;
        repeat (10) begin
            step();
            if (last_pv != 0) nrst++;
        end
        chk("rst_no_pulse", 32'(nrst), 32'd0);
        req = 4'b1001;
        step();
        chk("rst_first_grant", 32'(last_ack), 32'h1);
        req = 4'b1000;
        step();
        req = '0;
        repeat (9) step();

        // Random gapped traffic; requesters hold operands until acked.
        pending = '0;
        for (int t = 0; t < 300; t++) begin
            for (int n = 0; n < N; n++) begin
                if (!pending[n] && $urandom_range(0, 99) < 45) begin
                    pending[n] = 1'b1;
                    opa[n] = ($urandom_range(0, 7) == 0) ? 24'h800000 : 24'($urandom);
                    opb[n] = ($urandom_range(0, 7) == 0) ? 24'h7FFFFF : 24'($urandom);
                end
            end
            req = pending;
            step();
            pending = pending & ~last_ack;
        end
        req = '0;
        repeat (10) step();
        chk("issued_vs_returned", 32'(recv), 32'(issued));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
